nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that adds two `4*NIBBLES`-bit operands one nibble per clock, using a single 4-bit ripple-carry slice with a registered carry between nibbles. It sits directly around the 4-bit ripple adder stage. It feeds that stage operand nibbles and consumes its sum and carry, trading latency for area when operands are wider than 4 bits. Operation is controlled by a start/busy/done handshake.

---
 rtl/nibble_serial_adder.sv | 137 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two 4*NIBBLES-bit operands one nibble per clock
// through a single 4-bit ripple-carry slice, carrying between nibbles in a
// register. start/busy/done handshake; results held until the next completion.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic              accept;
  logic              last_nib;

  logic [W-1:0]      a_sh;
  logic [W-1:0]      b_sh;
  logic [W-1:0]      res_sh;
  logic              carry_reg;
  logic [IDX_W-1:0]  idx;

  logic [5:0]        slice;
  logic [3:0]        slice_sum;
  logic              slice_co;
  logic              slice_c3;
  logic [W-1:0]      res_next;

  // 4-bit full-adder chain; returns {carry into bit 3, carry out, sum}.
  function automatic logic [5:0] nib_add(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       ci);
    logic [3:0] s;
    logic [4:0] c;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[3], c[4], s};
  endfunction

  // Slice evaluation on the current low nibbles; new sum nibble enters the top.
  always_comb begin
    slice     = nib_add(a_sh[3:0], b_sh[3:0], carry_reg);
    slice_sum = slice[3:0];
    slice_co  = slice[4];
    slice_c3  = slice[5];
    res_next  = (W'(slice_sum) << (W - 4)) | (res_sh >> 4);
  end

  // Next-state logic: accept start in IDLE/DONE, finish after the last nibble.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    last_nib = (idx == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, operand shifters, carry register and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      if (accept) begin
        a_sh      <= a;
        b_sh      <= b;
        res_sh    <= '0;
        carry_reg <= cin;
        idx       <= '0;
        busy      <= 1'b1;
      end else if (state == ADD) begin
        a_sh      <= a_sh >> 4;
        b_sh      <= b_sh >> 4;
        res_sh    <= res_next;
        carry_reg <= slice_co;
        idx       <= idx + 1'b1;
        if (last_nib) begin
          sum  <= res_next;
          cout <= slice_co;
          ovf  <= slice_c3 ^ slice_co;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start an add and follow it to completion; start is dropped after E0.
  task automatic do_add(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec,
                        input logic eo);
    start = 1'b1; a = av; b = bv; cin = ci;
    tick();                      // E0
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_done_e0"}, done, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, "_busy_mid"}, busy, 1);
      chk({tag, "_done_mid"}, done, 0);
    end
    tick();                      // E0+4
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();                      // E0+5
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_sum_hold"}, sum, es);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 16'h0; b = 16'h0; cin = 1'b0;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // Basic adds
    do_add("add_5_6",      16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0);
    do_add("add_1234",     16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    // Carry ripple
    do_add("ripple_ffff",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_add("ripple_cin",   16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0);
    // Signed overflow
    do_add("ovf_pos",      16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_add("ovf_neg",      16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // start during ADD is ignored
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    tick();                      // E0
    start = 1'b0;
    tick();                      // E0+1
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    tick();                      // E0+2, ignored
    start = 1'b0;
    chk("ign_busy", busy, 1);
    tick();                      // E0+3
    chk("ign_done_early", done, 0);
    tick();                      // E0+4
    chk("ign_done", done, 1);
    chk("ign_sum", sum, 16'h0002);
    chk("ign_cout", cout, 0);
    tick();
    chk("ign_done_clr", done, 0);
    chk("ign_idle_busy", busy, 0);

    // start reasserted in the DONE cycle
    start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    tick();                      // E0
    start = 1'b0;
    tick(); tick(); tick();
    tick();                      // E0+4
    chk("b2b_done1", done, 1);
    chk("b2b_sum1", sum, 16'h0003);
    start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    tick();                      // E0+5, second accept
    start = 1'b0;
    chk("b2b_done1_clr", done, 0);
    chk("b2b_busy5", busy, 1);
    chk("b2b_sum_hold", sum, 16'h0003);
    for (int k = 6; k < 9; k++) begin
      tick();
      chk("b2b_busy_mid", busy, 1);
      chk("b2b_done_mid", done, 0);
    end
    tick();                      // E0+9
    chk("b2b_done2", done, 1);
    chk("b2b_busy_end", busy, 0);
    chk("b2b_sum2", sum, 16'h0100);
    chk("b2b_cout2", cout, 0);
    tick();

    // Reset in the middle of an add
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    tick();                      // E0
    start = 1'b0;
    tick();                      // E0+1
    rst_n = 1'b0;
    tick();                      // E0+2, reset
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    do_add("after_abort",  16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
